// File: rtl/rr_sel_stage.sv
`default_nettype none
// ============================================================================
//  Module   : rr_sel_stage
//  Purpose  : N-channel registered selection stage with valid/ready
//             handshakes. Each cycle one requesting channel is granted by
//             round-robin, fixed priority or forced index, and its word is
//             captured into a one-entry output register.
//  Ports    :
//    clk, rst_n   rising-edge clock, asynchronous active-low reset
//    mode         00 round-robin, 01 fixed priority, 10 forced, 11 as 00
//    sel_idx      channel granted in forced mode
//    in_data      channel i on bits [i*WIDTH +: WIDTH]
//    in_valid     per-channel request
//    in_ready     per-channel accept (one-hot or zero)
//    out_data     registered selected word
//    out_idx      channel that produced out_data
//    out_valid    out_data/out_idx hold a word
//    out_ready    consumer accept
//    xfer_cnt     count of completed output handshakes (wraps mod 2^16)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_sel_stage #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int IDXW   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              mode,
    input  logic [IDXW-1:0]         sel_idx,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [IDXW-1:0]         out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [15:0]             xfer_cnt
);

    localparam logic [1:0] c_MODE_FIXED  = 2'b01;
    localparam logic [1:0] c_MODE_FORCED = 2'b10;

    logic [WIDTH-1:0] r_out_data;
    logic [IDXW-1:0]  r_out_idx;
    logic             r_out_valid;
    logic [IDXW-1:0]  r_ptr;
    logic [15:0]      r_xfer_cnt;

    logic             w_load_en;
    logic             w_is_rr;
    logic             w_grant_vld;
    logic [IDXW-1:0]  w_grant_idx;
    logic [WIDTH-1:0] w_grant_data;
    logic [IDXW-1:0]  w_ptr_next;
    int               w_rr_ch;

    // The output register may take a new word when empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    // Mode 11 is an alias of round-robin.
    assign w_is_rr = (mode != c_MODE_FIXED) && (mode != c_MODE_FORCED);

    // Grant selection. Loops scan downward so the last hit written is the
    // lowest index (fixed) or the smallest offset from ptr (round-robin).
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_rr_ch     = 0;
        if (mode == c_MODE_FIXED) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = IDXW'(i);
                end
            end
        end else if (mode == c_MODE_FORCED) begin
            // Comparing against every legal index means an out-of-range
            // sel_idx simply never matches, giving no grant.
            for (int i = 0; i < NUM_IN; i++) begin
                if ((sel_idx == IDXW'(i)) && in_valid[i]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = IDXW'(i);
                end
            end
        end else begin
            for (int off = NUM_IN - 1; off >= 0; off--) begin
                w_rr_ch = (int'(r_ptr) + off) % NUM_IN;
                if (in_valid[w_rr_ch]) begin
                    w_grant_vld = 1'b1;
                    w_grant_idx = IDXW'(w_rr_ch);
                end
            end
        end
    end

    // Word of the granted channel.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (w_grant_idx == IDXW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer moves to the channel after the one just served.
    assign w_ptr_next = (w_grant_idx == IDXW'(NUM_IN - 1)) ? '0 : (w_grant_idx + 1'b1);

    // rst_n gating keeps in_ready low during reset even though the empty
    // output register would otherwise report load_en high.
    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && w_load_en && w_grant_vld &&
                                  (w_grant_idx == IDXW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (r_out_valid && out_ready) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if (w_load_en) begin
                if (w_grant_vld) begin
                    r_out_data  <= w_grant_data;
                    r_out_idx   <= w_grant_idx;
                    r_out_valid <= 1'b1;
                    if (w_is_rr) begin
                        r_ptr <= w_ptr_next;
                    end
                end else begin
                    // Nothing to load: drop valid, keep last data/index.
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rr_sel_stage
//  Purpose  : Self-checking bench for rr_sel_stage (NUM_IN=4, WIDTH=32).
//             Expected words are queued when stimulus is driven and popped
//             when the stage presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rr_sel_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int IDXW   = 2;

    typedef struct packed {
        logic [IDXW-1:0]  idx;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [1:0]              mode;
    logic [IDXW-1:0]         sel_idx;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [IDXW-1:0]         out_idx;
    logic                    out_valid;
    logic                    out_ready;
    logic [15:0]             xfer_cnt;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t exp_w;

    rr_sel_stage #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_idx   (sel_idx),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic push_exp(input logic [IDXW-1:0] i, input logic [WIDTH-1:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    // Reset pulse between clock edges.
    task automatic do_reset();
        in_valid = '0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        mode      = 2'b00;
        sel_idx   = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_init: got v=%b d=%h i=%0d cnt=%0d, want 0/0/0/0",
                     out_valid, out_data, out_idx, xfer_cnt);
        end
        #2 rst_n = 1'b1;
        mode = 2'b01;
        set_ch(0, 32'h1234_5678);
        in_valid = 4'b0001;
        push_exp(2'd0, 32'h1234_5678);
        tick();
        exp_w = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
            errors++;
            $display("FAIL reset_load: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                     out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
        end
        // Request pending and consumer ready, so only reset can hold in_ready low.
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
            xfer_cnt !== 16'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got v=%b d=%h i=%0d cnt=%0d rdy=%b, want all 0",
                     out_valid, out_data, out_idx, xfer_cnt, in_ready);
        end
        in_valid  = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_round_robin();
        tick();
        mode      = 2'b00;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_IN; i++) set_ch(i, 32'hA0 + i);
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(IDXW'(k % NUM_IN), 32'hA0 + (k % NUM_IN));
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_w = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data ||
                xfer_cnt !== 16'(k)) begin
                errors++;
                $display("FAIL rr_word%0d: got v=%b i=%0d d=%h cnt=%0d, want v=1 i=%0d d=%h cnt=%0d",
                         k, out_valid, out_idx, out_data, xfer_cnt, exp_w.idx, exp_w.data, k);
            end
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd5) begin
            errors++;
            $display("FAIL rr_drain: got v=%b cnt=%0d, want v=0 cnt=5", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_fixed_priority();
        mode = 2'b01;
        for (int i = 0; i < NUM_IN; i++) set_ch(i, 32'hB0 + i);
        in_valid = 4'b1110;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL fixed_ready1: got %b, want 0010", in_ready);
        end
        push_exp(2'd1, 32'hB1);
        tick();
        exp_w = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
            errors++;
            $display("FAIL fixed_first: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                     out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
        end
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0001) begin
                errors++;
                $display("FAIL fixed_ready0_%0d: got %b, want 0001", k, in_ready);
            end
            push_exp(2'd0, 32'hB0);
            tick();
            exp_w = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
                errors++;
                $display("FAIL fixed_ch0_%0d: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                         k, out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_forced();
        mode    = 2'b10;
        sel_idx = 2'd2;
        set_ch(0, 32'h1111_1111);
        set_ch(2, 32'hDEAD_BEEF);
        in_valid = 4'b0101;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL forced_ready: got %b, want 0100", in_ready);
        end
        push_exp(2'd2, 32'hDEAD_BEEF);
        tick();
        exp_w = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
            errors++;
            $display("FAIL forced_word: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                     out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
        end
        in_valid = 4'b0001;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL forced_noreq_ready: got %b, want 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_idx !== 2'd2 || out_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL forced_drop: got v=%b i=%0d d=%h, want v=0 i=2 d=deadbeef",
                     out_valid, out_idx, out_data);
        end
        in_valid = '0;
    endtask

    // The earlier round-robin run left ptr at 1; other modes must not move it.
    task automatic test_rr_resume();
        mode = 2'b00;
        for (int i = 0; i < NUM_IN; i++) set_ch(i, 32'hC0 + i);
        in_valid = 4'b1111;
        push_exp(2'd1, 32'hC1);
        push_exp(2'd2, 32'hC2);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_w = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
                errors++;
                $display("FAIL rr_resume%0d: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                         k, out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
            end
        end
        mode = 2'b11;
        push_exp(2'd3, 32'hC3);
        push_exp(2'd0, 32'hC0);
        for (int k = 0; k < 2; k++) begin
            tick();
            exp_w = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data) begin
                errors++;
                $display("FAIL mode11_rr%0d: got v=%b i=%0d d=%h, want v=1 i=%0d d=%h",
                         k, out_valid, out_idx, out_data, exp_w.idx, exp_w.data);
            end
        end
        in_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        mode      = 2'b01;
        out_ready = 1'b1;
        set_ch(0, 32'hD0);
        in_valid = 4'b0001;
        push_exp(2'd0, 32'hD0);
        tick();
        exp_w = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_w.data || xfer_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bp_load: got v=%b d=%h cnt=%0d, want v=1 d=%h cnt=0",
                     out_valid, out_data, xfer_cnt, exp_w.data);
        end
        out_ready = 1'b0;
        set_ch(0, 32'hD1);
        in_valid = 4'b0011;
        push_exp(2'd0, 32'hD1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data ||
                in_ready !== 4'b0000 || xfer_cnt !== 16'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b i=%0d d=%h rdy=%b cnt=%0d, want v=1 i=0 d=%h rdy=0000 cnt=0",
                         k, out_valid, out_idx, out_data, in_ready, xfer_cnt, exp_w.data);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 0001", in_ready);
        end
        tick();
        exp_w = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_idx !== exp_w.idx || out_data !== exp_w.data ||
            xfer_cnt !== 16'd1) begin
            errors++;
            $display("FAIL bp_replace: got v=%b i=%0d d=%h cnt=%0d, want v=1 i=%0d d=%h cnt=1",
                     out_valid, out_idx, out_data, xfer_cnt, exp_w.idx, exp_w.data);
        end
        in_valid = '0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_drain: got v=%b cnt=%0d, want v=0 cnt=2", out_valid, xfer_cnt);
        end
    endtask

    // Edge n loads word n and completes the handshake of word n-1.
    task automatic test_counter_wrap();
        do_reset();
        mode      = 2'b01;
        out_ready = 1'b1;
        in_valid  = 4'b0001;
        for (int n = 1; n <= 65538; n++) begin
            set_ch(0, 32'(n));
            tick();
            if (n == 65536) begin
                checks++;
                if (xfer_cnt !== 16'hFFFF || out_valid !== 1'b1 || out_data !== 32'(n)) begin
                    errors++;
                    $display("FAIL wrap_ffff: got cnt=%h v=%b d=%h, want cnt=ffff v=1 d=%h",
                             xfer_cnt, out_valid, out_data, 32'(n));
                end
            end else if (n == 65537) begin
                checks++;
                if (xfer_cnt !== 16'h0000 || out_valid !== 1'b1 || out_data !== 32'(n)) begin
                    errors++;
                    $display("FAIL wrap_0000: got cnt=%h v=%b d=%h, want cnt=0000 v=1 d=%h",
                             xfer_cnt, out_valid, out_data, 32'(n));
                end
            end else if (n == 65538) begin
                checks++;
                if (xfer_cnt !== 16'h0001 || out_valid !== 1'b1 || out_data !== 32'(n)) begin
                    errors++;
                    $display("FAIL wrap_0001: got cnt=%h v=%b d=%h, want cnt=0001 v=1 d=%h",
                             xfer_cnt, out_valid, out_data, 32'(n));
                end
            end
        end
        in_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_fixed_priority();
        test_forced();
        test_rr_resume();
        test_backpressure();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/rr_sel_stage.md
# rr_sel_stage

Parametrised N-channel, WIDTH-bit registered selection stage with valid/ready handshakes on every input and on the output. It is the sequential successor to the datapath's combinational 2:1 word selectors. Each cycle it picks one requesting channel by round-robin, fixed-priority or forced index, and captures that word into a one-entry output register. The block sits between multiple producers (ALU, memory read, PC+4, immediate paths) and a single consumer stage.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- NUM_IN, 4, number of input channels (>=2, need not be a power of 2)
- IDXW, max(1, clog2(NUM_IN)), channel-index width (derived, not overridden)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  2  00 round-robin, 01 fixed priority, 10 forced index, 11 treated as 00
- sel_idx  input  IDXW  channel used in forced mode
- in_data  input  NUM_IN*WIDTH  channel i on bits [i*WIDTH +: WIDTH]
- in_valid  input  NUM_IN  per-channel request
- in_ready  output  NUM_IN  per-channel accept, one-hot or zero
- out_data  output  WIDTH  registered selected word
- out_idx  output  IDXW  channel that produced out_data
- out_valid  output  1  out_data/out_idx hold a word
- out_ready  input  1  consumer accept
- xfer_cnt  output  16  count of completed output handshakes

## Operation
- load_en = !out_valid || out_ready; the output register accepts a new word only when load_en is high.
- Grant selection is combinational over in_valid. At most one grant is issued:
  - Round-robin: search upward from pointer ptr, wrapping NUM_IN-1 to 0, for the first valid channel.
  - Fixed priority: the lowest-index valid channel wins.
  - Forced: grant sel_idx if in_valid[sel_idx] is high. If sel_idx >= NUM_IN, no grant.
- in_ready[i] = load_en && grant[i]. An input transfer occurs when in_valid[i] && in_ready[i].
- On an input transfer at the clock edge:
  - out_data <= that channel's word, out_idx <= i, out_valid <= 1.
  - In round-robin mode only, ptr <= (i+1) mod NUM_IN.
- If load_en is high and there is no grant, out_valid <= 0. out_data and out_idx keep their old values.
- On an output handshake (out_valid && out_ready), xfer_cnt increments mod 2^16.
- A mode or sel_idx change takes effect the same cycle for arbitration. It never alters a word already held.
- ptr is unchanged in modes 01 and 10. Returning to round-robin resumes from the stored ptr.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_idx=0, ptr=0, xfer_cnt=0.
- in_ready is combinationally 0 while rst_n is low.
- Reset asserted mid-transfer discards the held word immediately.
- Latency: an input accepted at edge k appears with out_valid=1 after edge k.
- Throughput: one word per cycle sustained when out_ready stays high; there are no bubbles.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_idx and out_valid are stable, and all in_ready are 0.
- A simultaneous output handshake and input transfer in the same cycle replaces the word with no gap, and xfer_cnt still increments.
- Combinational paths in_valid/mode/sel_idx/out_ready -> in_ready are intentional. There is no combinational path from any input to out_data, out_idx or out_valid.
- xfer_cnt wraps from 0xFFFF to 0x0000 with no flag.

## Test plan
- Reset: with a word held (out_valid=1, out_data=0x12345678), pulse rst_n low between edges -> all outputs 0 immediately, xfer_cnt=0, in_ready=0.
- Round-robin, NUM_IN=4, all in_valid=1, data ch i=0xA0+i, out_ready=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, out_data 0xA0..0xA3,0xA0, xfer_cnt 1..5.
- Fixed priority, in_valid=4'b1110 then 4'b1111 -> out_idx 1, then 0 every cycle; in_ready=4'b0001 during the second phase.
- Forced, sel_idx=2, ch2 data 0xDEADBEEF, in_valid=4'b0101 -> out_idx=2, out_data=0xDEADBEEF, in_ready[0]=0.
  - Same test with in_valid[2]=0 -> out_valid drops after one edge.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in_ready=0. Raise out_ready -> next word loads at that edge, out_valid stays 1.
- Counter wrap: 65537 back-to-back handshakes -> xfer_cnt reads 0x0000 after the 65536th and 0x0001 after the 65537th.
